// File: rtl/adc_power_acc.sv
// Windowed power integrator: sums |s|^2 of four signed 8-bit ADC lanes over 2^acc_len valid cycles
// and publishes the saturated 32-bit total with a one-cycle dump strobe.
module adc_power_acc #(
   parameter int ACC_W   = 48,
   parameter int MAX_LEN = 24
) (
   input  logic        user_clk,
   input  logic        user_rst_n,
   input  logic [31:0] adc_data,
   input  logic        adc_valid,
   input  logic        sync,
   input  logic [4:0]  acc_len,
   output logic [31:0] user_data_out,
   output logic        dump,
   output logic        sat_flag,
   output logic [15:0] dump_count
);

   localparam int CNT_W = MAX_LEN + 2;
   localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'(64'h0000_0000_FFFF_FFFF);

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [14:0] square8(input logic signed [7:0] s);
      logic [7:0]  mag;
      logic [15:0] p;
      mag = s[7] ? (~s + 8'd1) : s;
      p   = 16'(mag) * 16'(mag);
      return 15'(p);
   endfunction

   function automatic logic [31:0] sat32(input logic [ACC_W-1:0] v);
      return (v > OUT_MAX) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   state_t            state_q, state_d;
   logic              sync_pend_q, sync_pend_d;
   logic              vld_p1_q, vld_p1_d, start_p1_q, start_p1_d;
   logic              vld_p2_q, vld_p2_d, start_p2_q, start_p2_d;
   logic [14:0]       sq_p1_q [4];
   logic [14:0]       sq_p1_d [4];
   logic [16:0]       sum_p2_q, sum_p2_d;
   logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [4:0]        len_q, len_d, len_in, eff_len;
   logic [31:0]       out_q, out_d;
   logic              sat_q, sat_d, dump_q, dump_d;
   logic [15:0]       dcount_q, dcount_d;
   logic              win_full, take;

   // Stage 0 -> 1: window-start tagging and per-lane squares
   always_comb begin
      vld_p1_d    = adc_valid;
      start_p1_d  = adc_valid & (sync | sync_pend_q);
      sync_pend_d = adc_valid ? 1'b0 : (sync | sync_pend_q);
      for (int i = 0; i < 4; i++) begin
         sq_p1_d[i] = square8(adc_data[8*i +: 8]);
      end
   end

   // Stage 1 -> 2: lane sum
   always_comb begin
      vld_p2_d   = vld_p1_q;
      start_p2_d = start_p1_q;
      sum_p2_d   = 17'(sq_p1_q[0]) + 17'(sq_p1_q[1]) + 17'(sq_p1_q[2]) + 17'(sq_p1_q[3]);
   end

   // Stage 2 -> 3: accumulate, window completion and dump
   always_comb begin
      len_in   = (acc_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : acc_len;
      eff_len  = start_p2_q ? len_in : len_q;
      acc_sum  = (start_p2_q ? '0 : acc_q) + ACC_W'(sum_p2_q);
      cnt_inc  = start_p2_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
      win_full = (cnt_inc == (CNT_W'(1) << eff_len));

      take     = 1'b0;
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      out_d    = out_q;
      sat_d    = sat_q;
      dump_d   = 1'b0;
      dcount_d = dcount_q;

      case (state_q)
         IDLE: begin
            if (vld_p2_q && start_p2_q) begin
               state_d = RUN;
               take    = 1'b1;
            end
         end
         RUN: take = vld_p2_q;
      endcase

      if (take) begin
         len_d = eff_len;
         if (win_full) begin
            out_d    = sat32(acc_sum);
            sat_d    = (acc_sum > OUT_MAX);
            dump_d   = 1'b1;
            dcount_d = dcount_q + 16'd1;
            acc_d    = '0;
            cnt_d    = '0;
         end else begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q     <= IDLE;
         sync_pend_q <= 1'b0;
         vld_p1_q    <= 1'b0;
         start_p1_q  <= 1'b0;
         vld_p2_q    <= 1'b0;
         start_p2_q  <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         out_q       <= '0;
         sat_q       <= 1'b0;
         dump_q      <= 1'b0;
         dcount_q    <= '0;
      end else begin
         state_q     <= state_d;
         sync_pend_q <= sync_pend_d;
         vld_p1_q    <= vld_p1_d;
         start_p1_q  <= start_p1_d;
         vld_p2_q    <= vld_p2_d;
         start_p2_q  <= start_p2_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         out_q       <= out_d;
         sat_q       <= sat_d;
         dump_q      <= dump_d;
         dcount_q    <= dcount_d;
      end
   end

   // Datapath registers only move under the valid tags, so they carry no reset
   always_ff @(posedge user_clk) begin
      sq_p1_q  <= sq_p1_d;
      sum_p2_q <= sum_p2_d;
   end

   assign user_data_out = out_q;
   assign dump          = dump_q;
   assign sat_flag      = sat_q;
   assign dump_count    = dcount_q;

endmodule

// File: tb/tb_adc_power_acc.sv
// Bench for adc_power_acc: directed vector table, hand-written window corner cases and a
// randomized run checked cycle by cycle against a sample-level reference model.
module tb_adc_power_acc;

   logic        user_clk = 1'b0;
   logic        user_rst_n = 1'b0;
   logic [31:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic        sync = 1'b0;
   logic [4:0]  acc_len = '0;
   logic [31:0] user_data_out;
   logic        dump;
   logic        sat_flag;
   logic [15:0] dump_count;

   adc_power_acc dut (
      .user_clk      (user_clk),
      .user_rst_n    (user_rst_n),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .sync          (sync),
      .acc_len       (acc_len),
      .user_data_out (user_data_out),
      .dump          (dump),
      .sat_flag      (sat_flag),
      .dump_count    (dump_count)
   );

   always #5 user_clk = ~user_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [31:0] val;
      logic        sat;
   } exp_t;
   exp_t exp_q[$];

   localparam longint LIM32 = 64'h0000_0000_FFFF_FFFF;

   bit          m_armed, m_pend;
   longint      m_acc, m_cnt;
   int          m_len;
   logic [31:0] m_out;
   logic        m_sat;
   logic [15:0] m_dcnt;
   int          last_tag = -100;

   typedef struct {
      logic [31:0] data;
      logic [31:0] power;
   } vec_t;
   vec_t vecs[6];

   function automatic longint power4(input logic [31:0] d);
      longint p;
      p = 0;
      for (int i = 0; i < 4; i++) begin
         int v;
         v = $signed(d[8*i +: 8]);
         p += longint'(v * v);
      end
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_armed = 0;
      m_pend  = 0;
      m_acc   = 0;
      m_cnt   = 0;
      m_len   = 0;
      m_out   = '0;
      m_sat   = 1'b0;
      m_dcnt  = '0;
      exp_q.delete();
   endtask

   // Applies the window rules to the sample presented this cycle; a finished
   // window is expected on dump three cycles later.
   task automatic model_apply();
      bit   tag;
      exp_t e;
      tag = 0;
      if (adc_valid) begin
         tag    = sync || m_pend;
         m_pend = 0;
      end else if (sync) begin
         m_pend = 1;
      end
      if (!adc_valid) return;
      if (tag) begin
         m_armed  = 1;
         m_acc    = power4(adc_data);
         m_cnt    = 1;
         m_len    = (acc_len > 5'd24) ? 24 : int'(acc_len);
         last_tag = cyc;
      end else if (m_armed) begin
         m_acc += power4(adc_data);
         m_cnt++;
      end else begin
         return;
      end
      if (m_cnt == (longint'(1) << m_len)) begin
         e.cyc = cyc + 3;
         e.val = (m_acc > LIM32) ? 32'hFFFF_FFFF : m_acc[31:0];
         e.sat = (m_acc > LIM32);
         exp_q.push_back(e);
         m_acc = 0;
         m_cnt = 0;
      end
   endtask

   task automatic check_cycle();
      bit exp_dump;
      exp_dump = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (exp_dump) begin
         m_out  = exp_q[0].val;
         m_sat  = exp_q[0].sat;
         m_dcnt = m_dcnt + 16'd1;
         void'(exp_q.pop_front());
      end
      chk("dump", 32'(dump), 32'(exp_dump));
      chk("user_data_out", user_data_out, m_out);
      chk("sat_flag", 32'(sat_flag), 32'(m_sat));
      chk("dump_count", 32'(dump_count), 32'(m_dcnt));
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic s);
      adc_valid = v;
      adc_data  = d;
      sync      = s;
      model_apply();
      @(negedge user_clk);
      check_cycle();
      @(posedge user_clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0);
   endtask

   task automatic burst(input int n, input logic [31:0] d);
      for (int i = 0; i < n; i++) drive(1'b1, d, 1'b0);
   endtask

   initial begin
      logic [15:0] dc0;
      logic [31:0] rd;
      logic        rv, rs;

      vecs[0] = '{32'h8080_8080, 32'd65536};
      vecs[1] = '{32'h7F7F_7F7F, 32'd64516};
      vecs[2] = '{32'hFFFF_FFFF, 32'd4};
      vecs[3] = '{32'h0000_0000, 32'd0};
      vecs[4] = '{32'h817F_0180, 32'd48643};
      vecs[5] = '{32'h0500_FB00, 32'd50};

      model_reset();
      repeat (3) @(posedge user_clk);
      #1;
      chk("rst_out", user_data_out, 32'h0);
      chk("rst_dump", 32'(dump), 32'h0);
      chk("rst_sat", 32'(sat_flag), 32'h0);
      chk("rst_count", 32'(dump_count), 32'h0);
      user_rst_n = 1'b1;

      // Samples before any sync are dropped
      burst(4, 32'h0102_0304);
      idle(3);
      chk("nosync_count", 32'(dump_count), 32'h0);

      // Single-sample window
      acc_len = 5'd0;
      drive(1'b1, 32'h0102_0304, 1'b1);
      idle(1);
      chk("len0_early", 32'(dump), 32'h0);
      idle(1);
      chk("len0_dump", 32'(dump), 32'h1);
      chk("len0_out", user_data_out, 32'd30);
      chk("len0_count", 32'(dump_count), 32'h1);

      for (int i = 0; i < 6; i++) begin
         drive(1'b1, vecs[i].data, 1'b1);
         idle(2);
         chk("vec_dump", 32'(dump), 32'h1);
         chk("vec_out", user_data_out, vecs[i].power);
         chk("vec_sat", 32'(sat_flag), 32'h0);
      end

      // Four full-scale samples
      acc_len = 5'd2;
      drive(1'b1, 32'h8080_8080, 1'b1);
      burst(3, 32'h8080_8080);
      idle(1);
      chk("len2_early", 32'(dump), 32'h0);
      idle(1);
      chk("len2_dump", 32'(dump), 32'h1);
      chk("len2_out", user_data_out, 32'h0004_0000);
      chk("len2_sat", 32'(sat_flag), 32'h0);

      // Gapped valid pattern 1,0,0,1
      acc_len = 5'd1;
      drive(1'b1, 32'h0102_0304, 1'b1);
      idle(2);
      chk("gap_nodump", 32'(dump), 32'h0);
      drive(1'b1, 32'h0102_0304, 1'b0);
      idle(1);
      chk("gap_early", 32'(dump), 32'h0);
      idle(1);
      chk("gap_dump", 32'(dump), 32'h1);
      chk("gap_out", user_data_out, 32'd60);

      // Restart after five samples of an eight-sample window
      acc_len = 5'd3;
      idle(3);
      dc0 = dump_count;
      drive(1'b1, 32'h0102_0304, 1'b1);
      burst(4, 32'h0102_0304);
      drive(1'b1, 32'h7F7F_7F7F, 1'b1);
      burst(7, 32'h7F7F_7F7F);
      chk("restart_early", 32'(dump), 32'h0);
      chk("restart_nocount", 32'(dump_count), 32'(dc0));
      idle(2);
      chk("restart_dump", 32'(dump), 32'h1);
      chk("restart_out", user_data_out, 32'h0007_E020);
      chk("restart_count", 32'(dump_count), 32'(dc0 + 16'd1));

      // Saturating window of 2^16 full-scale samples
      acc_len = 5'd16;
      drive(1'b1, 32'h8080_8080, 1'b1);
      burst(65535, 32'h8080_8080);
      idle(2);
      chk("sat_dump", 32'(dump), 32'h1);
      chk("sat_out", user_data_out, 32'hFFFF_FFFF);
      chk("sat_flag", 32'(sat_flag), 32'h1);

      // Reset pulse mid-window
      acc_len = 5'd2;
      idle(3);
      drive(1'b1, 32'h0102_0304, 1'b1);
      drive(1'b1, 32'h0102_0304, 1'b0);
      adc_valid  = 1'b0;
      sync       = 1'b0;
      user_rst_n = 1'b0;
      #2;
      chk("midrst_out", user_data_out, 32'h0);
      chk("midrst_sat", 32'(sat_flag), 32'h0);
      chk("midrst_dump", 32'(dump), 32'h0);
      chk("midrst_count", 32'(dump_count), 32'h0);
      model_reset();
      @(posedge user_clk);
      #1;
      user_rst_n = 1'b1;
      cyc++;
      burst(4, 32'h0102_0304);
      idle(3);
      chk("postrst_count", 32'(dump_count), 32'h0);
      drive(1'b1, 32'h0102_0304, 1'b1);
      burst(3, 32'h0102_0304);
      idle(2);
      chk("postrst_dump", 32'(dump), 32'h1);
      chk("postrst_out", user_data_out, 32'd120);
      chk("postrst_dcount", 32'(dump_count), 32'h1);

      // Randomized traffic with gaps, re-syncs and mid-window acc_len changes
      drive(1'b1, $urandom, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         rv = ($urandom_range(0, 9) < 7);
         rs = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 3))
            0:       rd = 32'h8080_8080;
            1:       rd = 32'h7F7F_7F7F;
            default: rd = $urandom;
         endcase
         if ((cyc - last_tag) >= 3 && $urandom_range(0, 19) == 0)
            acc_len = 5'($urandom_range(0, 4));
         drive(rv, rd, rs);
      end
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
